// File: rtl/rns_to_int_mrc_if.sv
// Handshake bundle between an RNS word source and the mixed-radix converter.
// Source side drives in_valid/in_rns/out_ready; converter side drives the rest.
interface rns_to_int_mrc_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rns;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    modport master (
        output in_valid, in_rns, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_rns, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/rns_to_int_mrc.sv
// Purpose: 4-channel RNS word -> binary integer by mixed-radix conversion, one digit per cycle.
// Latency: word accepted in cycle T, result valid in cycle T+5; one word per 6 cycles minimum.
// Backpressure: result held until out_ready; in_ready only in IDLE. Option: RNS_SIGNED_OUT_EN.
module rns_to_int_mrc #(
    parameter int M0 = 233,
    parameter int M1 = 239,
    parameter int M2 = 241,
    parameter int M3 = 251
) (
    input  logic             clk,
    input  logic             reset,
    rns_to_int_mrc_if.slave  bus
);

    function automatic logic [7:0] inv_mod(input int a, input int m);
        inv_mod = 8'd0;
        for (int i = 1; i < m; i++) begin
            if (((a % m) * i) % m == 1) inv_mod = 8'(i);
        end
    endfunction

    // b is reduced first so an out-of-range residue can never underflow the subtract
    function automatic logic [7:0] sub_mod(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] m);
        logic [8:0] s;
        s = 9'(a) + 9'(m) - 9'(b % m);
        sub_mod = 8'(s % 9'(m));
    endfunction

    function automatic logic [7:0] mul_mod(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] m);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        mul_mod = 8'(p % 16'(m));
    endfunction

    localparam logic [7:0] MW0 = 8'(M0);
    localparam logic [7:0] MW1 = 8'(M1);
    localparam logic [7:0] MW2 = 8'(M2);
    localparam logic [7:0] MW3 = 8'(M3);

    localparam logic [7:0] INV01 = inv_mod(M0, M1);
    localparam logic [7:0] INV02 = inv_mod(M0, M2);
    localparam logic [7:0] INV03 = inv_mod(M0, M3);
    localparam logic [7:0] INV12 = inv_mod(M1, M2);
    localparam logic [7:0] INV13 = inv_mod(M1, M3);
    localparam logic [7:0] INV23 = inv_mod(M2, M3);

    localparam logic [31:0] P1 = 32'(M0);
    localparam logic [31:0] P2 = 32'(M0 * M1);
    localparam logic [31:0] P3 = 32'(M0 * M1 * M2);

`ifdef RNS_SIGNED_OUT_EN
    localparam logic [31:0] MTOT = P3 * 32'(M3);
    localparam logic [31:0] HALF = (MTOT - 32'd1) >> 1;
`endif

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] D1   = 3'd1;
    localparam logic [2:0] D2   = 3'd2;
    localparam logic [2:0] D3   = 3'd3;
    localparam logic [2:0] SUM  = 3'd4;
    localparam logic [2:0] OUT  = 3'd5;

    logic [2:0]  state;
    logic [7:0]  r1, r2, r3;
    logic [7:0]  a0, a1, a2, a3;
    logic        err;
    logic [31:0] out_data;
    logic        out_err;

    logic [7:0]  d1, d2, d3;
    logic [7:0]  t2, t3a, t3b;
    logic [31:0] sum_raw, sum_res;

    // Each digit peels the previous ones off the residue and scales by the modular inverse
    always_comb begin
        d1  = mul_mod(sub_mod(r1, a0, MW1), INV01, MW1);

        t2  = mul_mod(sub_mod(r2, a0, MW2), INV02, MW2);
        d2  = mul_mod(sub_mod(t2, a1, MW2), INV12, MW2);

        t3a = mul_mod(sub_mod(r3, a0, MW3), INV03, MW3);
        t3b = mul_mod(sub_mod(t3a, a1, MW3), INV13, MW3);
        d3  = mul_mod(sub_mod(t3b, a2, MW3), INV23, MW3);
    end

    always_comb begin
        sum_raw = 32'(a0) + 32'(a1) * P1 + 32'(a2) * P2 + 32'(a3) * P3;
`ifdef RNS_SIGNED_OUT_EN
        sum_res = (sum_raw > HALF) ? (sum_raw - MTOT) : sum_raw;
`else
        sum_res = sum_raw;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            r1       <= 8'd0;
            r2       <= 8'd0;
            r3       <= 8'd0;
            a0       <= 8'd0;
            a1       <= 8'd0;
            a2       <= 8'd0;
            a3       <= 8'd0;
            err      <= 1'b0;
            out_data <= 32'd0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a0    <= bus.in_rns[7:0];
                        r1    <= bus.in_rns[15:8];
                        r2    <= bus.in_rns[23:16];
                        r3    <= bus.in_rns[31:24];
                        err   <= (bus.in_rns[7:0]   >= MW0) || (bus.in_rns[15:8]  >= MW1) ||
                                 (bus.in_rns[23:16] >= MW2) || (bus.in_rns[31:24] >= MW3);
                        state <= D1;
                    end
                end
                D1: begin
                    a1    <= d1;
                    state <= D2;
                end
                D2: begin
                    a2    <= d2;
                    state <= D3;
                end
                D3: begin
                    a3    <= d3;
                    state <= SUM;
                end
                SUM: begin
                    out_data <= err ? 32'd0 : sum_res;
                    out_err  <= err;
                    state    <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = out_data;
    assign bus.out_err   = out_err;

endmodule

// File: tb/tb_rns_to_int_mrc.sv
// Scoreboard bench for rns_to_int_mrc: expected {err,data} queued per word, popped on output.
module tb_rns_to_int_mrc;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rns_to_int_mrc_if bus();

    rns_to_int_mrc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam longint MTOT = 64'd3368562317;
    localparam longint HALF = 64'd1684281158;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_rns(input longint x);
        to_rns = {8'(x % 251), 8'(x % 241), 8'(x % 239), 8'(x % 233)};
    endfunction

    function automatic logic [31:0] model_out(input longint x);
`ifdef RNS_SIGNED_OUT_EN
        model_out = (x > HALF) ? 32'(x - MTOT) : 32'(x);
`else
        model_out = 32'(x);
`endif
    endfunction

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic convert(input logic [31:0] rns, input logic [32:0] expv, input int hold);
        int lat;
        logic [32:0] e;
        exp_q.push_back(expv);
        wait_in_ready();
        bus.in_rns   = rns;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        // accepted in cycle T; we are now in cycle T+1
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd5);
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e[31:0]);
        check("out_err", 32'(bus.out_err), 32'(e[32]));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = (i % 2 == 0);
                bus.in_rns   = 32'h01010101;
                @(negedge clk);
            end
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'b0;
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", bus.out_data, e[31:0]);
            check("hold_err", 32'(bus.out_err), 32'(e[32]));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("valid_drop", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        longint x;
        int stale;
        bus.in_valid  = 1'b0;
        bus.in_rns    = 32'd0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        convert(32'h00000000, {1'b0, 32'd0}, 0);
        convert(32'hF7242C44, {1'b0, 32'd1000}, 0);
        convert(32'h0C0C0C0C, {1'b0, 32'd12}, 0);
`ifdef RNS_SIGNED_OUT_EN
        convert(32'hFAF0EEE8, {1'b0, 32'hFFFFFFFF}, 0);
`else
        convert(32'hFAF0EEE8, {1'b0, 32'hC8C82E8C}, 0);
`endif
        convert(to_rns(HALF), {1'b0, model_out(HALF)}, 0);
        convert(to_rns(HALF + 1), {1'b0, model_out(HALF + 1)}, 0);
        convert(32'hF7242C44, {1'b0, 32'd1000}, 10);
        convert(32'h000000E9, {1'b1, 32'd0}, 0);
        convert(32'hF7242C44, {1'b0, 32'd1000}, 0);
        convert(32'hFF000000, {1'b1, 32'd0}, 3);

        for (int i = 0; i < 6; i++) begin
            x = longint'($urandom) % MTOT;
            convert(to_rns(x), {1'b0, model_out(x)}, i % 3);
        end

        // reset while the converter sits in D2
        wait_in_ready();
        bus.in_rns   = to_rns(64'd123456789);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        bus.out_ready = 1'b0;
        check("midrst_no_stale", 32'(stale), 32'd0);

        convert(32'h0C0C0C0C, {1'b0, 32'd12}, 0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
